crypto1_fb_cand_collector: RTL

//  Drives the Fb preimage enumerator and collects its output.
//  - Per request: picks the keystream bit, resets the enumerator, captures its 8 nibble candidates.
//  - Drops candidates that conflict with already-known state bits.
//  - Queues the survivors in a FIFO for the state-extension stage downstream.

---
 rtl/crypto1_fb_cand_collector.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/crypto1_fb_cand_collector.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | crypto1_fb_cand_collector                                                |
// | Sequences the Fb preimage enumerator, filters its 8 candidates against   |
// | known state bits and queues survivors. Option: CRYPTO1_FB_CHECK_EN.      |
// | Rev 1.0 - initial release                                                |
// +--------------------------------------------------------------------------+
module crypto1_fb_cand_collector #(
  parameter int DEPTH = 16
) (
  input  logic       CLK,
  input  logic       RESETn,
  input  logic       REQ_VALID,
  output logic       REQ_READY,
  input  logic       REQ_BIT,
  input  logic [3:0] REQ_MASK,
  input  logic [3:0] REQ_VAL,
  output logic       ENUM_BIT,
  output logic       ENUM_RESETn,
  input  logic [3:0] ENUM_OUT,
  output logic       CAND_VALID,
  input  logic       CAND_READY,
  output logic [3:0] CAND_DATA,
  output logic       CAND_LAST,
  output logic       DONE,
  output logic [3:0] MATCH_CNT,
  output logic       ERR
);
  localparam int c_AW = $clog2(DEPTH);
  localparam logic [c_AW:0] c_LIMIT = (c_AW+1)'(DEPTH - 8);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ERST  = 2'd1,
    S_RUN   = 2'd2,
    S_DRAIN = 2'd3
  } state_t;

  state_t        r_state;
  logic          r_bit;
  logic [3:0]    r_mask;
  logic [3:0]    r_val;
  logic [2:0]    r_k;
  logic          r_capv;
  logic          r_hold_v;
  logic [3:0]    r_hold;
  logic [3:0]    r_cnt;
  logic          r_done;
  logic [3:0]    r_match;
  logic [4:0]    r_mem [DEPTH];
  logic [c_AW-1:0] r_wp;
  logic [c_AW-1:0] r_rp;
  logic [c_AW:0]   r_count;

  logic       w_accept;
  logic       w_surv;
  logic       w_pop;
  logic [1:0] w_push_n;
  logic [4:0] w_push0;
  logic [4:0] w_push1;

  assign REQ_READY   = RESETn & (r_state == S_IDLE) & (r_count <= c_LIMIT);
  assign ENUM_RESETn = RESETn & (r_state != S_ERST);
  assign ENUM_BIT    = r_bit;
  assign CAND_VALID  = (r_count != '0);
  assign {CAND_LAST, CAND_DATA} = r_mem[r_rp];
  assign DONE        = r_done;
  assign MATCH_CNT   = r_match;

  assign w_accept = REQ_VALID & REQ_READY;
  assign w_surv   = r_capv & (((ENUM_OUT ^ r_val) & r_mask) == 4'd0);
  assign w_pop    = CAND_VALID & CAND_READY;

  // The held survivor becomes non-last once a newer one shows up; at DRAIN
  // both the held entry and the final capture may land in the same cycle.
  always_comb begin
    w_push_n = 2'd0;
    w_push0  = 5'd0;
    w_push1  = 5'd0;
    if (r_state == S_DRAIN) begin
      if (w_surv && r_hold_v) begin
        w_push_n = 2'd2;
        w_push0  = {1'b0, r_hold};
        w_push1  = {1'b1, ENUM_OUT};
      end else if (w_surv) begin
        w_push_n = 2'd1;
        w_push0  = {1'b1, ENUM_OUT};
      end else if (r_hold_v) begin
        w_push_n = 2'd1;
        w_push0  = {1'b1, r_hold};
      end
    end else if (w_surv && r_hold_v) begin
      w_push_n = 2'd1;
      w_push0  = {1'b0, r_hold};
    end
  end

  always_ff @(posedge CLK) begin
    if (!RESETn) begin
      r_state  <= S_IDLE;
      r_bit    <= 1'b0;
      r_mask   <= 4'd0;
      r_val    <= 4'd0;
      r_k      <= 3'd0;
      r_capv   <= 1'b0;
      r_hold_v <= 1'b0;
      r_hold   <= 4'd0;
      r_cnt    <= 4'd0;
      r_done   <= 1'b0;
      r_match  <= 4'd0;
    end else begin
      r_done <= 1'b0;
      r_capv <= (r_state == S_RUN);
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_bit    <= REQ_BIT;
            r_mask   <= REQ_MASK;
            r_val    <= REQ_VAL;
            r_cnt    <= 4'd0;
            r_hold_v <= 1'b0;
            r_state  <= S_ERST;
          end
        end
        S_ERST: begin
          r_k     <= 3'd0;
          r_state <= S_RUN;
        end
        S_RUN: begin
          r_k <= r_k + 3'd1;
          if (r_k == 3'd7) r_state <= S_DRAIN;
          if (w_surv) begin
            r_hold   <= ENUM_OUT;
            r_hold_v <= 1'b1;
            r_cnt    <= r_cnt + 4'd1;
          end
        end
        S_DRAIN: begin
          r_state  <= S_IDLE;
          r_done   <= 1'b1;
          r_match  <= r_cnt + 4'(w_surv);
          r_hold_v <= 1'b0;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (!RESETn) begin
      r_wp    <= '0;
      r_rp    <= '0;
      r_count <= '0;
    end else begin
      r_wp    <= r_wp + c_AW'(w_push_n);
      r_rp    <= r_rp + c_AW'(w_pop);
      r_count <= r_count + (c_AW+1)'(w_push_n) - (c_AW+1)'(w_pop);
    end
  end

  always_ff @(posedge CLK) begin
    if (w_push_n != 2'd0) r_mem[r_wp] <= w_push0;
    if (w_push_n == 2'd2) r_mem[r_wp + c_AW'(1)] <= w_push1;
  end

`ifdef CRYPTO1_FB_CHECK_EN
  localparam logic [15:0] c_FB_TABLE = 16'hB48E;
  logic r_err;
  always_ff @(posedge CLK) begin
    if (!RESETn) r_err <= 1'b0;
    else if (r_capv && (c_FB_TABLE[ENUM_OUT] != r_bit)) r_err <= 1'b1;
  end
  assign ERR = r_err;
`else
  assign ERR = 1'b0;
`endif

endmodule
`default_nettype wire
